// File: rtl/cache_line_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// cache_line_xfer_ctrl_if
// Groups every handshake/bus signal of the cache line transfer controller.
//   master : the controller (cache_line_xfer_ctrl) - samples the miss request,
//            drives the memory word strobes/address/data and the cache write.
//   slave  : the surrounding cache tag logic, cache data array and memory.
// Signals:
//   miss_i, victim_dirty_i, miss_addr_i, victim_addr_i : miss request side
//   evict_data_i                                      : cache word for writeback
//   mem_rdata_i, mem_ack_i                            : memory response
//   mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o       : memory request
//   word_idx_o, cache_we_o, cache_wdata_o             : cache data array access
//   busy_o, done_o                                    : status
// ---------------------------------------------------------------------------
interface cache_line_xfer_ctrl_if #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);

  logic                  miss_i;
  logic                  victim_dirty_i;
  logic [ADDR_WIDTH-1:0] miss_addr_i;
  logic [ADDR_WIDTH-1:0] victim_addr_i;
  logic [DATA_WIDTH-1:0] evict_data_i;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ack_i;
  logic                  mem_rd_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [IDX_W-1:0]      word_idx_o;
  logic                  cache_we_o;
  logic [DATA_WIDTH-1:0] cache_wdata_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    input  miss_i, victim_dirty_i, miss_addr_i, victim_addr_i,
           evict_data_i, mem_rdata_i, mem_ack_i,
    output mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o,
           word_idx_o, cache_we_o, cache_wdata_o, busy_o, done_o
  );

  modport slave (
    output miss_i, victim_dirty_i, miss_addr_i, victim_addr_i,
           evict_data_i, mem_rdata_i, mem_ack_i,
    input  mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o,
           word_idx_o, cache_we_o, cache_wdata_o, busy_o, done_o
  );
endinterface

// File: rtl/cache_line_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// cache_line_xfer_ctrl
// On a cache miss, writes back the dirty victim line word by word (if dirty)
// and then fills the missing line word by word over a word-wide memory bus.
// Ports:
//   CLK  : clock, all state changes on posedge
//   CLR  : synchronous active-high reset
//   xfer : cache_line_xfer_ctrl_if.master - miss request, memory bus, cache
//          data array write port and status (see the interface file)
// Configuration:
//   CACHE_XFER_CWF_EN : when defined, the fill starts at the word holding the
//                       missing address and wraps around the line (critical
//                       word first). Writeback order is always 0..WPL-1.
// ---------------------------------------------------------------------------
module cache_line_xfer_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32
) (
  input logic                     CLK,
  input logic                     CLR,
  cache_line_xfer_ctrl_if.master  xfer
);
  localparam int IDX_W = $clog2(WORDS_PER_LINE);
  localparam int OFF_W = IDX_W + 2;  // word index + byte-in-word bits

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~(ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_victim_base;
  logic [ADDR_WIDTH-1:0] r_miss_base;
`ifdef CACHE_XFER_CWF_EN
  logic [IDX_W-1:0]      r_idx0;
`endif

  logic                  w_last;
  logic [IDX_W-1:0]      w_fill_idx;
  logic [ADDR_WIDTH-1:0] w_word_off;

  // WPL is a power of two, so the last word is the all-ones count.
  assign w_last = &r_count;

`ifdef CACHE_XFER_CWF_EN
  // Natural IDX_W-bit overflow gives the wrap around the line.
  assign w_fill_idx = r_idx0 + r_count;
`else
  assign w_fill_idx = r_count;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_state       <= S_IDLE;
      r_count       <= '0;
      r_victim_base <= '0;
      r_miss_base   <= '0;
`ifdef CACHE_XFER_CWF_EN
      r_idx0        <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_count <= '0;
          if (xfer.miss_i) begin
            // Latched copies make later changes on the request inputs harmless.
            r_victim_base <= xfer.victim_addr_i & LINE_MASK;
            r_miss_base   <= xfer.miss_addr_i & LINE_MASK;
`ifdef CACHE_XFER_CWF_EN
            r_idx0        <= xfer.miss_addr_i[OFF_W-1:2];
`endif
            r_state       <= xfer.victim_dirty_i ? S_WB : S_FILL;
          end
        end
        S_WB: begin
          if (xfer.mem_ack_i) begin
            r_count <= r_count + 1'b1;
            if (w_last) r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (xfer.mem_ack_i) begin
            r_count <= r_count + 1'b1;
            if (w_last) r_state <= S_DONE;
          end
        end
        default: begin  // S_DONE
          r_count <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte offset of the current word; zero outside WB/FILL because the index
  // output is forced to zero there.
  assign w_word_off = ADDR_WIDTH'({xfer.word_idx_o, 2'b00});

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would infer a latch.
  always_comb begin
    xfer.mem_rd_o      = 1'b0;
    xfer.mem_wr_o      = 1'b0;
    xfer.mem_addr_o    = '0;
    xfer.mem_wdata_o   = '0;
    xfer.word_idx_o    = '0;
    xfer.cache_we_o    = 1'b0;
    xfer.cache_wdata_o = '0;
    xfer.busy_o        = (r_state != S_IDLE);
    xfer.done_o        = (r_state == S_DONE);
    case (r_state)
      S_WB: begin
        xfer.mem_wr_o    = 1'b1;
        xfer.word_idx_o  = r_count;
        xfer.mem_addr_o  = r_victim_base + w_word_off;
        xfer.mem_wdata_o = xfer.evict_data_i;
      end
      S_FILL: begin
        xfer.mem_rd_o      = 1'b1;
        xfer.word_idx_o    = w_fill_idx;
        xfer.mem_addr_o    = r_miss_base + w_word_off;
        // Cache write happens in the same cycle the memory returns the word.
        xfer.cache_we_o    = xfer.mem_ack_i;
        xfer.cache_wdata_o = xfer.mem_rdata_i;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_line_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_line_xfer_ctrl
// Directed bench for cache_line_xfer_ctrl (WPL=4, 32-bit address and data).
// Inputs are driven 1 time unit after posedge; outputs are checked on negedge.
// Expected fill order follows CACHE_XFER_CWF_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_cache_line_xfer_ctrl;
  localparam int WPL = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_err;
  int   cyc;
  int   acc_cyc;

  cache_line_xfer_ctrl_if #(.WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) xfer ();

  cache_line_xfer_ctrl #(.WORDS_PER_LINE(WPL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK  (clk),
    .CLR  (clr),
    .xfer (xfer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Fill-order index of the k-th filled word for a miss whose word field is idx0.
  function automatic int fill_idx(input int idx0, input int k);
`ifdef CACHE_XFER_CWF_EN
    return (idx0 + k) % WPL;
`else
    return k + 0 * idx0;
`endif
  endfunction

  function automatic logic [31:0] word_addr(input logic [31:0] base, input int idx);
    logic [31:0] off;
    off = 32'(idx * 4);
    return base + off;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One IDLE cycle: present a request (or not) and confirm nothing is active.
  task automatic idle_cycle(input string tag, input logic miss, input logic dirty,
                            input logic [31:0] maddr, input logic [31:0] vaddr,
                            input logic ack);
    xfer.miss_i         = miss;
    xfer.victim_dirty_i = dirty;
    xfer.miss_addr_i    = maddr;
    xfer.victim_addr_i  = vaddr;
    xfer.mem_ack_i      = ack;
    @(negedge clk);
    check({tag, ".busy"},  xfer.busy_o,     1'b0);
    check({tag, ".rd"},    xfer.mem_rd_o,   1'b0);
    check({tag, ".wr"},    xfer.mem_wr_o,   1'b0);
    check({tag, ".we"},    xfer.cache_we_o, 1'b0);
    check({tag, ".done"},  xfer.done_o,     1'b0);
    check({tag, ".idx"},   xfer.word_idx_o, 0);
    check({tag, ".addr"},  xfer.mem_addr_o, 32'h0);
    acc_cyc = cyc;
    next_cycle();
  endtask

  // One WB or FILL cycle with the given memory response.
  task automatic bus_cycle(input string tag, input logic exp_rd, input logic exp_wr,
                           input logic [31:0] exp_addr, input int exp_idx,
                           input logic ack, input logic [31:0] data);
    xfer.mem_ack_i    = ack;
    xfer.mem_rdata_i  = data;
    xfer.evict_data_i = data;
    @(negedge clk);
    check({tag, ".rd"},   xfer.mem_rd_o,   exp_rd);
    check({tag, ".wr"},   xfer.mem_wr_o,   exp_wr);
    check({tag, ".addr"}, xfer.mem_addr_o, exp_addr);
    check({tag, ".idx"},  xfer.word_idx_o, exp_idx);
    check({tag, ".busy"}, xfer.busy_o,     1'b1);
    check({tag, ".done"}, xfer.done_o,     1'b0);
    check({tag, ".we"},   xfer.cache_we_o, exp_rd & ack);
    if (exp_rd) check({tag, ".cwdata"}, xfer.cache_wdata_o, data);
    if (exp_wr) check({tag, ".mwdata"}, xfer.mem_wdata_o,   data);
    next_cycle();
  endtask

  task automatic done_cycle(input string tag, input int exp_lat);
    xfer.mem_ack_i = 1'b0;
    @(negedge clk);
    check({tag, ".done"}, xfer.done_o,   1'b1);
    check({tag, ".busy"}, xfer.busy_o,   1'b1);
    check({tag, ".rd"},   xfer.mem_rd_o, 1'b0);
    check({tag, ".wr"},   xfer.mem_wr_o, 1'b0);
    check({tag, ".lat"},  cyc - acc_cyc, exp_lat);
    next_cycle();
  endtask

  task automatic clean_fill(input string tag, input logic [31:0] base, input int idx0);
    for (int w = 0; w < WPL; w++) begin
      bus_cycle(tag, 1'b1, 1'b0, word_addr(base, fill_idx(idx0, w)),
                fill_idx(idx0, w), 1'b1, 32'hA000_0000 + 32'(w));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    acc_cyc = 0;
    clr = 1'b1;
    xfer.miss_i = 1'b0;
    xfer.victim_dirty_i = 1'b0;
    xfer.miss_addr_i = '0;
    xfer.victim_addr_i = '0;
    xfer.evict_data_i = '0;
    xfer.mem_rdata_i = '0;
    xfer.mem_ack_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state: everything low while CLR is held.
    @(negedge clk);
    check("rst.busy", xfer.busy_o,     1'b0);
    check("rst.done", xfer.done_o,     1'b0);
    check("rst.rd",   xfer.mem_rd_o,   1'b0);
    check("rst.wr",   xfer.mem_wr_o,   1'b0);
    check("rst.we",   xfer.cache_we_o, 1'b0);
    check("rst.addr", xfer.mem_addr_o, 32'h0);
    check("rst.idx",  xfer.word_idx_o, 0);
    next_cycle();
    clr = 1'b0;

    // Clean miss 0x100, stray ack during the accept cycle, done at +5.
    idle_cycle("clean.acc", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
    xfer.miss_i = 1'b0;
    clean_fill("clean", 32'h0000_0100, 0);
    done_cycle("clean.done", 1 + WPL);
    idle_cycle("clean.stray", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Dirty miss: victim 0x2F4 written back from 0x2F0, then fill 0x100.
    // miss_i toggles and miss_addr_i moves during the transfer: ignored.
    idle_cycle("dirty.acc", 1'b1, 1'b1, 32'h0000_0100, 32'h0000_02F4, 1'b0);
    for (int w = 0; w < WPL; w++) begin
      xfer.miss_i      = w[0];
      xfer.miss_addr_i = 32'h0000_0500;
      bus_cycle("dirty.wb", 1'b0, 1'b1, word_addr(32'h0000_02F0, w), w, 1'b1,
                32'hE000_0000 + 32'(w));
    end
    for (int w = 0; w < WPL; w++) begin
      xfer.miss_i        = ~w[0];
      xfer.victim_addr_i = 32'h0000_0700;
      bus_cycle("dirty.fill", 1'b1, 1'b0, word_addr(32'h0000_0100, fill_idx(0, w)),
                fill_idx(0, w), 1'b1, 32'hB000_0000 + 32'(w));
    end
    xfer.miss_i = 1'b0;
    done_cycle("dirty.done", 1 + 2 * WPL);

    // Ack held low for 3 cycles on fill word 2.
    idle_cycle("stall.acc", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 1'b0);
    xfer.miss_i = 1'b0;
    bus_cycle("stall.w0", 1'b1, 1'b0, 32'h0000_0100, 0, 1'b1, 32'h1111_0000);
    bus_cycle("stall.w1", 1'b1, 1'b0, 32'h0000_0104, 1, 1'b1, 32'h1111_0001);
    for (int s = 0; s < 3; s++) begin
      bus_cycle("stall.wait", 1'b1, 1'b0, 32'h0000_0108, 2, 1'b0, 32'hDEAD_BEEF);
    end
    bus_cycle("stall.w2", 1'b1, 1'b0, 32'h0000_0108, 2, 1'b1, 32'h1111_0002);
    bus_cycle("stall.w3", 1'b1, 1'b0, 32'h0000_010C, 3, 1'b1, 32'h1111_0003);
    done_cycle("stall.done", 1 + WPL + 3);

    // CLR during fill word 1: back to IDLE with no done_o, then a new miss.
    idle_cycle("clr.acc", 1'b1, 1'b0, 32'h0000_0300, 32'h0, 1'b0);
    xfer.miss_i = 1'b0;
    bus_cycle("clr.w0", 1'b1, 1'b0, 32'h0000_0300, 0, 1'b1, 32'h2222_0000);
    clr = 1'b1;
    bus_cycle("clr.w1", 1'b1, 1'b0, 32'h0000_0304, 1, 1'b0, 32'h2222_0001);
    clr = 1'b0;
    idle_cycle("clr.after", 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0);
    xfer.miss_i = 1'b0;
    clean_fill("clr.refill", 32'h0000_0200, 0);
    done_cycle("clr.done", 1 + WPL);

    // Miss at the top of the address space (word field 2).
    idle_cycle("top.acc", 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 1'b0);
    xfer.miss_i = 1'b0;
    clean_fill("top", 32'hFFFF_FFF0, 2);
    done_cycle("top.done", 1 + WPL);
    idle_cycle("top.idle", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
